// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard controller for the 5-stage RISC-V pipeline. A per-register
// scoreboard records how many cycles remain before a pending result can be
// forwarded. From it the unit raises decode stalls, branch flushes and
// EX-stage forwarding selects. An external freeze holds the whole pipeline.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   validD                decode holds a real instruction
//   RS1D, RS2D            decode source registers
//   useRS1D, useRS2D      source register actually read
//   RdD, RegwriteD        decode destination and its write enable
//   latD                  cycles after leaving D until the result is forwardable
//   PCsrcE                branch/jump taken in EX
//   ext_stall             whole-pipeline freeze (memory wait states)
//   RS1E, RS2E            EX source registers for forwarding
//   RdM, RegwriteM        M-stage destination and write enable
//   RdW, RegwriteW        W-stage destination and write enable
//   stallF, stallD        hold the PC and the IF/ID register
//   flushD, flushE        clear the IF/ID and ID/EX registers
//   ForwardAE, ForwardBE  00 = register file, 01 = ResultW, 10 = ALUresultM
//   stall_cnt, flush_cnt  performance counters
//
// Build option
//   HAZ_PERF_EN  when defined, stall_cnt/flush_cnt are live counters;
//                otherwise both outputs are tied to zero with no flops.
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int ADDR_W  = 5,
  parameter int MAX_LAT = 3,
  parameter int LAT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validD,
  input  logic [ADDR_W-1:0] RS1D,
  input  logic [ADDR_W-1:0] RS2D,
  input  logic              useRS1D,
  input  logic              useRS2D,
  input  logic [ADDR_W-1:0] RdD,
  input  logic              RegwriteD,
  input  logic [LAT_W-1:0]  latD,
  input  logic              PCsrcE,
  input  logic              ext_stall,
  input  logic [ADDR_W-1:0] RS1E,
  input  logic [ADDR_W-1:0] RS2E,
  input  logic [ADDR_W-1:0] RdM,
  input  logic [ADDR_W-1:0] RdW,
  input  logic              RegwriteM,
  input  logic              RegwriteW,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0] r_busy [NREG];
  logic [NREG-1:0]  w_busy_nz;
  logic             w_haz;
  logic             w_accept;
  logic             w_alloc;
  logic [LAT_W-1:0] w_lat_sat;

  function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] lat);
    if (lat > MAX_LAT_V) return MAX_LAT_V;
    return lat;
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [ADDR_W-1:0] rs,
    input logic [ADDR_W-1:0] rd_m,
    input logic [ADDR_W-1:0] rd_w,
    input logic              we_m,
    input logic              we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs)) return 2'b10;
    if (we_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_busy_nz[i] = (r_busy[i] != '0);
    end
  end

  assign w_haz     = validD & ((useRS1D & w_busy_nz[RS1D]) | (useRS2D & w_busy_nz[RS2D]));
  assign w_accept  = validD & ~rst & ~ext_stall & ~PCsrcE & ~w_haz;
  assign w_alloc   = w_accept & RegwriteD & (RdD != '0);
  assign w_lat_sat = sat_lat(latD);

  // Scoreboard: a fresh issue overrides the countdown of its own entry;
  // every other pending entry counts down unless the pipeline is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_busy[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i == 0) begin
          r_busy[i] <= '0;
        end else if (w_alloc && (RdD == ADDR_W'(i))) begin
          r_busy[i] <= w_lat_sat;
        end else if (!ext_stall && (r_busy[i] != '0)) begin
          r_busy[i] <= r_busy[i] - LAT_W'(1);
        end
      end
    end
  end

  // Stall/flush priority: reset, freeze, taken branch, data hazard.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (ext_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
    end else if (PCsrcE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (w_haz) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  assign ForwardAE = rst ? 2'b00 : fwd_sel(RS1E, RdM, RdW, RegwriteM, RegwriteW);
  assign ForwardBE = rst ? 2'b00 : fwd_sel(RS2E, RdM, RdW, RegwriteM, RegwriteW);

`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  // stallD is already 0 during reset; flush_cnt counts only branch flushes,
  // which cannot occur while frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stallD) r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (!ext_stall && PCsrcE) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NREG    = 32;
  localparam int ADDR_W  = 5;
  localparam int MAX_LAT = 3;
  localparam int LAT_W   = 2;
  localparam int PERF_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              validD = 1'b0;
  logic [ADDR_W-1:0] RS1D = '0, RS2D = '0, RdD = '0;
  logic              useRS1D = 1'b0, useRS2D = 1'b0, RegwriteD = 1'b0;
  logic [LAT_W-1:0]  latD = '0;
  logic              PCsrcE = 1'b0, ext_stall = 1'b0;
  logic [ADDR_W-1:0] RS1E = '0, RS2E = '0, RdM = '0, RdW = '0;
  logic              RegwriteM = 1'b0, RegwriteW = 1'b0;
  logic              stallF, stallD, flushD, flushE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG(NREG), .ADDR_W(ADDR_W), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst(rst), .validD(validD),
    .RS1D(RS1D), .RS2D(RS2D), .useRS1D(useRS1D), .useRS2D(useRS2D),
    .RdD(RdD), .RegwriteD(RegwriteD), .latD(latD),
    .PCsrcE(PCsrcE), .ext_stall(ext_stall),
    .RS1E(RS1E), .RS2E(RS2E), .RdM(RdM), .RdW(RdW),
    .RegwriteM(RegwriteM), .RegwriteW(RegwriteW),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic       rst, validD, u1, u2, rw, pcsrc, ext, rwm, rww;
    logic [4:0] rs1, rs2, rd, rs1e, rs2e, rdm, rdw;
    logic [1:0] lat;
  } in_t;

  typedef struct {
    in_t        in;
    logic [3:0] ctrl;  // {stallF, stallD, flushD, flushE}
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: an entry is pending until a "ready tick"; the tick
  // advances once per unfrozen cycle.
  longint      tick_m;
  longint      ready_m [NREG];
  int unsigned stall_m, flush_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v.rst = 0; v.validD = 0; v.u1 = 0; v.u2 = 0; v.rw = 0; v.pcsrc = 0; v.ext = 0;
    v.rwm = 0; v.rww = 0; v.rs1 = 0; v.rs2 = 0; v.rd = 0; v.rs1e = 0; v.rs2e = 0;
    v.rdm = 0; v.rdw = 0; v.lat = 0;
    return v;
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 0) && (ready_m[r] > tick_m);
  endfunction

  function automatic bit m_haz(input in_t v);
    return v.validD && ((v.u1 && m_busy(v.rs1)) || (v.u2 && m_busy(v.rs2)));
  endfunction

  function automatic logic [3:0] m_ctrl(input in_t v);
    if (v.rst)    return 4'b0011;
    if (v.ext)    return 4'b1100;
    if (v.pcsrc)  return 4'b0011;
    if (m_haz(v)) return 4'b1101;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] m_fwd(input in_t v, input logic [4:0] rs);
    if (v.rst) return 2'b00;
    if (v.rwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
    if (v.rww && v.rdw != 0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_update(input in_t v);
    logic [3:0] c;
    int lat;
    c = m_ctrl(v);
    if (v.rst) begin
      for (int i = 0; i < NREG; i++) ready_m[i] = 0;
      stall_m = 0;
      flush_m = 0;
    end else begin
      if (v.validD && !v.ext && !v.pcsrc && !m_haz(v) && v.rw && v.rd != 0) begin
        lat = (int'(v.lat) > MAX_LAT) ? MAX_LAT : int'(v.lat);
        ready_m[v.rd] = tick_m + 1 + lat;
      end
      if (c[2]) stall_m++;
      if (!v.ext && v.pcsrc) flush_m++;
      if (!v.ext) tick_m++;
    end
  endtask

  task automatic drive(input in_t v);
    rst = v.rst; validD = v.validD; RS1D = v.rs1; RS2D = v.rs2;
    useRS1D = v.u1; useRS2D = v.u2; RdD = v.rd; RegwriteD = v.rw; latD = v.lat;
    PCsrcE = v.pcsrc; ext_stall = v.ext; RS1E = v.rs1e; RS2E = v.rs2e;
    RdM = v.rdm; RdW = v.rdw; RegwriteM = v.rwm; RegwriteW = v.rww;
  endtask

  task automatic cycle(input in_t v, input string name, input logic [3:0] ec,
                       input logic [1:0] efa, input logic [1:0] efb);
    @(negedge clk);
    drive(v);
    #1;
    chk({name, ".ctrl"}, {28'd0, stallF, stallD, flushD, flushE}, {28'd0, ec});
    chk({name, ".fwdA"}, {30'd0, ForwardAE}, {30'd0, efa});
    chk({name, ".fwdB"}, {30'd0, ForwardBE}, {30'd0, efb});
`ifdef HAZ_PERF_EN
    chk({name, ".stall_cnt"}, stall_cnt, stall_m);
    chk({name, ".flush_cnt"}, flush_cnt, flush_m);
`else
    chk({name, ".stall_cnt"}, stall_cnt, 32'd0);
    chk({name, ".flush_cnt"}, flush_cnt, 32'd0);
`endif
    @(posedge clk);
    model_update(v);
  endtask

  task automatic add_vec(input in_t v, input logic [3:0] c, input logic [1:0] fa, input logic [1:0] fb);
    vec_t e;
    e.in = v; e.ctrl = c; e.fa = fa; e.fb = fb;
    tbl.push_back(e);
  endtask

  initial begin
    in_t v, cons;
    tick_m = 0; stall_m = 0; flush_m = 0;
    for (int i = 0; i < NREG; i++) ready_m[i] = 0;
    drive(idle());
    rst = 1'b1;

    // Vector table, applied with an empty scoreboard.
    v = idle(); v.rdm = 3; v.rdw = 3; v.rwm = 1; v.rww = 1; v.rs1e = 3;       add_vec(v, 4'b0000, 2'b10, 2'b00);
    v = idle(); v.rdm = 0; v.rdw = 0; v.rwm = 1; v.rww = 1;                   add_vec(v, 4'b0000, 2'b00, 2'b00);
    v = idle(); v.rdw = 4; v.rww = 1; v.rs1e = 4; v.rs2e = 4;                 add_vec(v, 4'b0000, 2'b01, 2'b01);
    v = idle(); v.rdm = 6; v.rdw = 6; v.rww = 1; v.rs1e = 1; v.rs2e = 6;      add_vec(v, 4'b0000, 2'b00, 2'b01);
    v = idle(); v.rdm = 2; v.rwm = 1; v.rdw = 8; v.rww = 1; v.rs1e = 8; v.rs2e = 2; add_vec(v, 4'b0000, 2'b01, 2'b10);
    v = idle(); v.validD = 1; v.rs1 = 4; v.u1 = 1; v.pcsrc = 1;               add_vec(v, 4'b0011, 2'b00, 2'b00);
    v = idle(); v.ext = 1; v.pcsrc = 1;                                      add_vec(v, 4'b1100, 2'b00, 2'b00);
    v = idle(); v.rst = 1; v.ext = 1; v.rdm = 3; v.rwm = 1; v.rs1e = 3;       add_vec(v, 4'b0011, 2'b00, 2'b00);
    v = idle(); v.validD = 1; v.u1 = 1; v.u2 = 1;                            add_vec(v, 4'b0000, 2'b00, 2'b00);

    // Power-on reset.
    v = idle(); v.rst = 1;
    cycle(v, "por0", 4'b0011, 2'b00, 2'b00);
    cycle(v, "por1", 4'b0011, 2'b00, 2'b00);

    foreach (tbl[i]) cycle(tbl[i].in, $sformatf("tbl%0d", i), tbl[i].ctrl, tbl[i].fa, tbl[i].fb);

    // Reset in the middle of a stall clears the scoreboard.
    v = idle(); v.validD = 1; v.rd = 7; v.rw = 1; v.lat = 3;
    cycle(v, "rst.issue", 4'b0000, 2'b00, 2'b00);
    cons = idle(); cons.validD = 1; cons.rs1 = 7; cons.u1 = 1;
    cycle(cons, "rst.stall", 4'b1101, 2'b00, 2'b00);
    v = cons; v.rst = 1; v.rdm = 3; v.rwm = 1; v.rs1e = 3; v.rs2e = 3;
    cycle(v, "rst.hold0", 4'b0011, 2'b00, 2'b00);
    cycle(v, "rst.hold1", 4'b0011, 2'b00, 2'b00);
    cycle(cons, "rst.after", 4'b0000, 2'b00, 2'b00);

    // Load-use: one bubble, then forward from W.
    v = idle(); v.validD = 1; v.rd = 5; v.rw = 1; v.lat = 1;
    cycle(v, "lu.issue", 4'b0000, 2'b00, 2'b00);
    cons = idle(); cons.validD = 1; cons.rs1 = 5; cons.u1 = 1;
    cycle(cons, "lu.stall", 4'b1101, 2'b00, 2'b00);
    cycle(cons, "lu.go", 4'b0000, 2'b00, 2'b00);
    v = idle(); v.rdw = 5; v.rww = 1; v.rs1e = 5;
    cycle(v, "lu.fwdW", 4'b0000, 2'b01, 2'b00);

    // Multi-cycle producer: exactly three bubbles.
    v = idle(); v.validD = 1; v.rd = 7; v.rw = 1; v.lat = 3;
    cycle(v, "mc.issue", 4'b0000, 2'b00, 2'b00);
    cons = idle(); cons.validD = 1; cons.rs2 = 7; cons.u2 = 1;
    for (int i = 0; i < 3; i++) cycle(cons, $sformatf("mc.stall%0d", i), 4'b1101, 2'b00, 2'b00);
    cycle(cons, "mc.go", 4'b0000, 2'b00, 2'b00);

    // Taken branch over a hazard: flush wins, D is not issued.
    v = idle(); v.rst = 1;
    cycle(v, "br.rst", 4'b0011, 2'b00, 2'b00);
    v = idle(); v.validD = 1; v.rd = 5; v.rw = 1; v.lat = 1;
    cycle(v, "br.issue", 4'b0000, 2'b00, 2'b00);
    v = idle(); v.validD = 1; v.rs1 = 5; v.u1 = 1; v.rd = 6; v.rw = 1; v.lat = 3; v.pcsrc = 1;
    cycle(v, "br.flush", 4'b0011, 2'b00, 2'b00);
    v = idle(); v.validD = 1; v.rs1 = 6; v.u1 = 1; v.rs2 = 5; v.u2 = 1;
    cycle(v, "br.after", 4'b0000, 2'b00, 2'b00);
`ifdef HAZ_PERF_EN
    chk("br.flush_cnt_one", flush_cnt, 32'd1);
`endif

    // Freeze holds the pending count.
    v = idle(); v.validD = 1; v.rd = 9; v.rw = 1; v.lat = 2;
    cycle(v, "fz.issue", 4'b0000, 2'b00, 2'b00);
    cons = idle(); cons.validD = 1; cons.rs1 = 9; cons.u1 = 1;
    v = cons; v.ext = 1;
    cycle(v, "fz.freeze0", 4'b1100, 2'b00, 2'b00);
    cycle(v, "fz.freeze1", 4'b1100, 2'b00, 2'b00);
    cycle(cons, "fz.stall0", 4'b1101, 2'b00, 2'b00);
    cycle(cons, "fz.stall1", 4'b1101, 2'b00, 2'b00);
    cycle(cons, "fz.go", 4'b0000, 2'b00, 2'b00);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      v = idle();
      v.rst    = ($urandom_range(0, 59) == 0);
      v.ext    = ($urandom_range(0, 7) == 0);
      v.pcsrc  = ($urandom_range(0, 9) == 0);
      v.validD = ($urandom_range(0, 5) != 0);
      v.u1     = $urandom_range(0, 1) != 0;
      v.u2     = $urandom_range(0, 1) != 0;
      v.rw     = $urandom_range(0, 3) != 0;
      v.rs1    = 5'($urandom_range(0, 7));
      v.rs2    = 5'($urandom_range(0, 7));
      v.rd     = 5'($urandom_range(0, 7));
      v.lat    = 2'($urandom_range(0, 3));
      v.rs1e   = 5'($urandom_range(0, 5));
      v.rs2e   = 5'($urandom_range(0, 5));
      v.rdm    = 5'($urandom_range(0, 5));
      v.rdw    = 5'($urandom_range(0, 5));
      v.rwm    = $urandom_range(0, 1) != 0;
      v.rww    = $urandom_range(0, 1) != 0;
      cycle(v, "rnd", m_ctrl(v), m_fwd(v, v.rs1e), m_fwd(v, v.rs2e));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard controller for the 5-stage RISC-V pipeline; successor to the forwarding-only hazard unit.
- Keeps a per-register scoreboard of pending writes, each with a configurable result latency. Supports loads and multi-cycle functional units.
- Generates decode stalls, branch flushes and EX-stage forwarding selects, and honours an external freeze from memory wait states.

Parameters:
- NREG, 32: architectural register count.
- ADDR_W, 5: register address width.
- MAX_LAT, 3: largest latency class accepted on latD.
- LAT_W, 2: width of latD and of each scoreboard counter. Must hold MAX_LAT.
- PERF_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- validD  in  1  decode holds a real instruction.
- RS1D, RS2D  in  ADDR_W  decode source registers.
- useRS1D, useRS2D  in  1  source register actually read.
- RdD  in  ADDR_W  decode destination register.
- RegwriteD  in  1  decode instruction writes RdD.
- latD  in  LAT_W  cycles after leaving D before the result can be forwarded (ALU=0, load=1, multi-cycle up to MAX_LAT).
- PCsrcE  in  1  branch/jump taken in EX.
- ext_stall  in  1  whole-pipeline freeze.
- RS1E, RS2E, RdM, RdW  in  ADDR_W  forwarding compare operands.
- RegwriteM, RegwriteW  in  1  write enables of the M and W stages.
- stallF, stallD  out  1  hold the PC and the IF/ID register.
- flushD, flushE  out  1  clear the IF/ID and ID/EX registers.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUresultM.
- stall_cnt, flush_cnt  out  PERF_W  performance counters.

Behaviour:
- Scoreboard: busy[NREG], each LAT_W bits. Reset clears all entries to 0. busy[0] is always 0.
- haz: (useRS1D & busy[RS1D]!=0) | (useRS2D & busy[RS2D]!=0), gated by validD.
- Issue accepted when validD & !rst & !ext_stall & !PCsrcE & !haz.
- On accept with RegwriteD & RdD!=0: busy[RdD] <= latD.
- Every other nonzero entry decrements by 1 per cycle while ext_stall=0, and holds while ext_stall=1.
- The issue write to RdD overrides that entry's decrement in the same cycle.
- latD > MAX_LAT saturates to MAX_LAT.
- Output priority, highest first:
  - rst: stallF=stallD=0, flushD=flushE=1, Forward*=00.
  - ext_stall: stallF=stallD=1, flushD=flushE=0. A held PCsrcE re-evaluates after release.
  - PCsrcE: stallF=stallD=0, flushD=flushE=1. A simultaneous haz is ignored and D is not issued.
  - haz: stallF=stallD=1, flushE=1, flushD=0. Inserts a bubble each cycle until the entry reaches 0.
  - otherwise: all stall/flush outputs 0.
- Stall length for a dependent instruction immediately following a producer = latD cycles.
- Stall/flush outputs are combinational from the registered scoreboard and current inputs.
- Forwarding is purely combinational, and is 00 during rst.
- ForwardAE = 10 if RegwriteM & RdM!=0 & RdM==RS1E; else 01 if RegwriteW & RdW!=0 & RdW==RS1E; else 00. M has priority over W.
- ForwardBE uses the same rule with RS2E.
- Reset mid-stall clears the scoreboard. The next cycle starts unstalled.

Optional Feature:
- Macro HAZ_PERF_EN.
- When defined:
  - stall_cnt increments on every cycle with stallD=1 and rst=0.
  - flush_cnt increments on every cycle with PCsrcE-driven flushD=1.
  - Both counters wrap at 2^PERF_W, clear on rst, and hold during ext_stall except for the stall_cnt count.
- When undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset: rst=1 for 2 cycles with busy entries set -> flushD=flushE=1, stall=0, Forward=00. After release a consumer of any register is not stalled.
- Load-use: issue RdD=5, latD=1, then consumer RS1D=5, useRS1D=1 -> stallF=stallD=flushE=1 for exactly 1 cycle, then issue. With the producer in W, RdW=RS1E=5 gives ForwardAE=01.
- Multi-cycle: issue RdD=7, latD=3, consumer RS2D=7 next -> exactly 3 stall cycles, busy[7] stepping 3,2,1,0.
- Branch over hazard: busy[5]=1, consumer in D, PCsrcE=1 same cycle -> stall 0, flushD=flushE=1, D not issued. With HAZ_PERF_EN, flush_cnt reads 1.
- Forward priority: RdM=RdW=RS1E=3 with RegwriteM=RegwriteW=1 -> ForwardAE=10. RS2E=RdM=0 with RegwriteM=1 -> ForwardBE=00.
- Freeze: issue RdD=9, latD=2, then ext_stall=1 for 2 cycles -> busy[9] holds at 2 with stallD=1 and flushE=0. After release it takes 2 more hazard stall cycles.
